// File: rtl/lsu_store_drain.sv
// lsu_store_drain: pops committed stores from the LSU store FIFO and issues them one at a
// time as valid/ready write requests to the data cache. Define STORE_DRAIN_TIMEOUT_EN for a response timeout.
module lsu_store_drain #(
   parameter int         ADDRW      = 32,
   parameter int         DATAW      = 32,
   parameter logic [7:0] TOUT_LIMIT = 8'd255
) (
   input  logic                          Clk,
   input  logic                          Rest,
   input  logic [ADDRW+DATAW+DATAW/8-1:0] FifoPreOut,
   input  logic                          FifoEmpty,
   output logic                          Rable,
   input  logic                          DrainEn,
   output logic                          ReqValid,
   input  logic                          ReqReady,
   output logic [ADDRW-1:0]              ReqAddr,
   output logic [DATAW-1:0]              ReqData,
   output logic [DATAW/8-1:0]            ReqStrb,
   input  logic                          RespValid,
   input  logic                          RespErr,
   output logic                          DrainBusy,
   output logic                          DrainErr
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       take;
   logic       resp;
   logic       pop;
   logic       tout;

   assign take  = DrainEn && !FifoEmpty;
   assign resp  = (state == WAIT) && RespValid;
   // A pop only happens from IDLE or on a response, so pops are always at least two cycles apart.
   assign pop   = ((state == IDLE) || resp) && take;
   assign Rable = pop;

`ifdef STORE_DRAIN_TIMEOUT_EN
   logic [7:0] tout_cnt;

   assign tout = (state == WAIT) && !RespValid && (tout_cnt == TOUT_LIMIT);

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         tout_cnt <= 8'd0;
      end else if ((state == REQ) && ReqReady) begin
         tout_cnt <= 8'd0;
      end else if ((state == WAIT) && !RespValid) begin
         tout_cnt <= tout_cnt + 8'd1;
      end
   end
`else
   logic [7:0] unused_tout;

   assign unused_tout = TOUT_LIMIT;
   assign tout        = 1'b0;
`endif

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = REQ;
         REQ:     if (ReqReady) state_nxt = WAIT;
         WAIT: begin
            if (resp)      state_nxt = pop ? REQ : IDLE;
            else if (tout) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         state     <= IDLE;
         ReqValid  <= 1'b0;
         DrainBusy <= 1'b0;
         DrainErr  <= 1'b0;
         ReqAddr   <= '0;
         ReqData   <= '0;
         ReqStrb   <= '0;
      end else begin
         state     <= state_nxt;
         ReqValid  <= (state_nxt == REQ);
         DrainBusy <= (state_nxt != IDLE);
         DrainErr  <= (resp && RespErr) || tout;
         if (pop) begin
            {ReqAddr, ReqData, ReqStrb} <= FifoPreOut;
         end
      end
   end

endmodule

// File: tb/tb_lsu_store_drain.sv
// Self-checking bench for lsu_store_drain: directed scenarios plus a randomized run
// checked against a transaction-level model (pending request / outstanding response).
module tb_lsu_store_drain;

   localparam int         ADDRW = 32;
   localparam int         DATAW = 32;
   localparam int         STRBW = DATAW / 8;
   localparam int         EW    = ADDRW + DATAW + STRBW;
   localparam logic [7:0] TOUT  = 8'd4;

   logic             Clk = 1'b0;
   logic             Rest;
   logic [EW-1:0]    FifoPreOut;
   logic             FifoEmpty;
   logic             Rable;
   logic             DrainEn;
   logic             ReqValid;
   logic             ReqReady;
   logic [ADDRW-1:0] ReqAddr;
   logic [DATAW-1:0] ReqData;
   logic [STRBW-1:0] ReqStrb;
   logic             RespValid;
   logic             RespErr;
   logic             DrainBusy;
   logic             DrainErr;

   int            errors = 0;
   int            checks = 0;
   logic [EW-1:0] fifo_q[$];
   logic          pop;

   always #5 Clk = ~Clk;

   lsu_store_drain #(.ADDRW(ADDRW), .DATAW(DATAW), .TOUT_LIMIT(TOUT)) dut (
      .Clk(Clk), .Rest(Rest), .FifoPreOut(FifoPreOut), .FifoEmpty(FifoEmpty), .Rable(Rable),
      .DrainEn(DrainEn), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
      .ReqData(ReqData), .ReqStrb(ReqStrb), .RespValid(RespValid), .RespErr(RespErr),
      .DrainBusy(DrainBusy), .DrainErr(DrainErr)
   );

   function automatic logic [EW-1:0] rand_entry();
      logic [STRBW-1:0] s;
      s = STRBW'($urandom());
      return {$urandom(), $urandom(), s};
   endfunction

   task automatic fifo_show();
      FifoEmpty  = (fifo_q.size() == 0);
      FifoPreOut = FifoEmpty ? '0 : fifo_q[0];
   endtask

   // FIFO model: head and empty flag update one cycle after a pop strobe.
   task automatic clk_step();
      #1 pop = Rable;
      @(posedge Clk);
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_show();
   endtask

   task automatic drain_idle();
      int n = 0;
      DrainEn = 1'b1; ReqReady = 1'b1; RespValid = 1'b1; RespErr = 1'b0;
      while ((fifo_q.size() != 0 || DrainBusy) && n < 50) begin
         clk_step();
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL drain_idle: still busy after %0d cycles, required idle", n);
      end
      RespValid = 1'b0;
      clk_step();
   endtask

   task automatic test_reset();
      Rest = 1'b0; DrainEn = 1'b0; ReqReady = 1'b0; RespValid = 1'b0; RespErr = 1'b0;
      fifo_show();
      #12;
      checks++;
      if ({Rable, ReqValid, DrainBusy, DrainErr} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000", {Rable, ReqValid, DrainBusy, DrainErr});
      end
      checks++;
      if ({ReqAddr, ReqData, ReqStrb} !== '0) begin
         errors++;
         $display("FAIL reset_fields: got %h required 0", {ReqAddr, ReqData, ReqStrb});
      end
      Rest = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_single();
      fifo_q.push_back({32'h0000_1000, 32'hDEAD_BEEF, 4'hF});
      fifo_show();
      DrainEn = 1'b1; ReqReady = 1'b1; RespValid = 1'b0;
      #1;
      checks++;
      if (Rable !== 1'b1 || ReqValid !== 1'b0) begin
         errors++;
         $display("FAIL single_c0: rable=%b reqvalid=%b required 1/0", Rable, ReqValid);
      end
      clk_step();
      #1;
      checks++;
      if (ReqValid !== 1'b1 || Rable !== 1'b0 || DrainBusy !== 1'b1) begin
         errors++;
         $display("FAIL single_c1: reqvalid=%b rable=%b busy=%b required 1/0/1", ReqValid, Rable, DrainBusy);
      end
      checks++;
      if (ReqAddr !== 32'h1000 || ReqData !== 32'hDEADBEEF || ReqStrb !== 4'hF) begin
         errors++;
         $display("FAIL single_fields: got %h %h %h required 00001000 deadbeef f", ReqAddr, ReqData, ReqStrb);
      end
      clk_step();
      RespValid = 1'b1;
      #1;
      checks++;
      if (ReqValid !== 1'b0 || DrainBusy !== 1'b1) begin
         errors++;
         $display("FAIL single_c2: reqvalid=%b busy=%b required 0/1", ReqValid, DrainBusy);
      end
      clk_step();
      RespValid = 1'b0;
      #1;
      checks++;
      if (DrainBusy !== 1'b0 || DrainErr !== 1'b0) begin
         errors++;
         $display("FAIL single_c3: busy=%b err=%b required 0/0", DrainBusy, DrainErr);
      end
      clk_step();
   endtask

   task automatic test_back_to_back();
      logic [EW-1:0] e[3];
      int n_rable = 0;
      int n_req   = 0;
      for (int i = 0; i < 3; i++) begin
         e[i] = rand_entry();
         fifo_q.push_back(e[i]);
      end
      fifo_show();
      DrainEn = 1'b1; ReqReady = 1'b1; RespValid = 1'b1; RespErr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (Rable) n_rable++;
         checks++;
         if (ReqValid !== (c == 1 || c == 3 || c == 5)) begin
            errors++;
            $display("FAIL b2b_valid cycle %0d: got %b", c, ReqValid);
         end
         if (ReqValid) begin
            checks++;
            if (n_req >= 3 || {ReqAddr, ReqData, ReqStrb} !== e[n_req]) begin
               errors++;
               $display("FAIL b2b_order req %0d: got %h", n_req, {ReqAddr, ReqData, ReqStrb});
            end
            n_req++;
         end
         clk_step();
      end
      checks++;
      if (n_rable != 3) begin
         errors++;
         $display("FAIL b2b_pops: got %0d required 3", n_rable);
      end
      RespValid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [EW-1:0] e0;
      logic bad = 1'b0;
      e0 = rand_entry();
      fifo_q.push_back(e0);
      fifo_q.push_back(rand_entry());
      fifo_show();
      DrainEn = 1'b1; ReqReady = 1'b0; RespValid = 1'b0;
      #1;
      checks++;
      if (Rable !== 1'b1) begin
         errors++;
         $display("FAIL bp_pop: got %b required 1", Rable);
      end
      clk_step();
      for (int i = 0; i < 5; i++) begin
         #1;
         if (ReqValid !== 1'b1 || Rable !== 1'b0 || {ReqAddr, ReqData, ReqStrb} !== e0) bad = 1'b1;
         clk_step();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bp_hold: request not held stable under backpressure, required held %h", e0);
      end
      ReqReady = 1'b1;
      #1;
      checks++;
      if (ReqValid !== 1'b1) begin
         errors++;
         $display("FAIL bp_accept: reqvalid=%b required 1", ReqValid);
      end
      clk_step();
      ReqReady = 1'b0;
      #1;
      checks++;
      if (ReqValid !== 1'b0 || DrainBusy !== 1'b1 || Rable !== 1'b0) begin
         errors++;
         $display("FAIL bp_wait: reqvalid=%b busy=%b rable=%b required 0/1/0", ReqValid, DrainBusy, Rable);
      end
      RespValid = 1'b1;
      #1;
      checks++;
      if (Rable !== 1'b1) begin
         errors++;
         $display("FAIL bp_next_pop: got %b required 1", Rable);
      end
      clk_step();
      drain_idle();
   endtask

   task automatic test_error();
      logic [EW-1:0] e1;
      e1 = rand_entry();
      fifo_q.push_back(rand_entry());
      fifo_q.push_back(e1);
      fifo_show();
      DrainEn = 1'b1; ReqReady = 1'b1; RespValid = 1'b0; RespErr = 1'b0;
      clk_step();
      clk_step();
      RespValid = 1'b1; RespErr = 1'b1;
      #1;
      checks++;
      if (Rable !== 1'b1 || DrainErr !== 1'b0) begin
         errors++;
         $display("FAIL err_resp_cycle: rable=%b err=%b required 1/0", Rable, DrainErr);
      end
      clk_step();
      RespErr = 1'b0;
      #1;
      checks++;
      if (DrainErr !== 1'b1) begin
         errors++;
         $display("FAIL err_pulse: got %b required 1", DrainErr);
      end
      checks++;
      if (ReqValid !== 1'b1 || {ReqAddr, ReqData, ReqStrb} !== e1) begin
         errors++;
         $display("FAIL err_next_entry: valid=%b got %h required %h", ReqValid, {ReqAddr, ReqData, ReqStrb}, e1);
      end
      clk_step();
      #1;
      checks++;
      if (DrainErr !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse_width: got %b required 0", DrainErr);
      end
      clk_step();
      RespValid = 1'b0;
      #1;
      checks++;
      if (DrainBusy !== 1'b0 || DrainErr !== 1'b0) begin
         errors++;
         $display("FAIL err_idle: busy=%b err=%b required 0/0", DrainBusy, DrainErr);
      end
      clk_step();
   endtask

   task automatic test_drain_en();
      logic bad = 1'b0;
      fifo_q.push_back(rand_entry());
      fifo_show();
      DrainEn = 1'b0; ReqReady = 1'b1; RespValid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (Rable !== 1'b0 || ReqValid !== 1'b0) bad = 1'b1;
         clk_step();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL en_low_idle: activity seen with DrainEn=0, required none");
      end
      DrainEn = 1'b1;
      clk_step();
      clk_step();
      fifo_q.push_back(rand_entry());
      fifo_show();
      DrainEn = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (DrainBusy !== 1'b1 || ReqValid !== 1'b0) bad = 1'b1;
         clk_step();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL en_drop_wait: transaction aborted after DrainEn fell, required still waiting");
      end
      RespValid = 1'b1;
      #1;
      checks++;
      if (Rable !== 1'b0) begin
         errors++;
         $display("FAIL en_drop_pop: got %b required 0", Rable);
      end
      clk_step();
      RespValid = 1'b0;
      #1;
      checks++;
      if (DrainBusy !== 1'b0) begin
         errors++;
         $display("FAIL en_drop_idle: busy=%b required 0", DrainBusy);
      end
      clk_step();
      drain_idle();
   endtask

   task automatic test_async_reset();
      fifo_q.push_back(rand_entry());
      fifo_show();
      DrainEn = 1'b1; ReqReady = 1'b0; RespValid = 1'b0;
      clk_step();
      #1;
      checks++;
      if (ReqValid !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: reqvalid=%b required 1", ReqValid);
      end
      #1 Rest = 1'b0;
      #1;
      checks++;
      if ({ReqValid, DrainBusy, DrainErr} !== 3'b000 || {ReqAddr, ReqData, ReqStrb} !== '0) begin
         errors++;
         $display("FAIL arst_clear: ctrl=%b fields=%h required 0", {ReqValid, DrainBusy, DrainErr}, {ReqAddr, ReqData, ReqStrb});
      end
      fifo_q.delete();
      fifo_show();
      @(negedge Clk);
      Rest = 1'b1;
      @(posedge Clk);
      #1;
      checks++;
      if (DrainBusy !== 1'b0 || Rable !== 1'b0) begin
         errors++;
         $display("FAIL arst_idle: busy=%b rable=%b required 0/0", DrainBusy, Rable);
      end
   endtask

`ifdef STORE_DRAIN_TIMEOUT_EN
   task automatic test_timeout();
      logic bad = 1'b0;
      fifo_q.push_back(rand_entry());
      fifo_show();
      DrainEn = 1'b1; ReqReady = 1'b1; RespValid = 1'b0; RespErr = 1'b0;
      for (int c = 0; c < 7; c++) begin
         #1;
         if (DrainErr !== 1'b0) bad = 1'b1;
         clk_step();
      end
      #1;
      checks++;
      if (bad || DrainErr !== 1'b1 || DrainBusy !== 1'b0) begin
         errors++;
         $display("FAIL timeout: early=%b err=%b busy=%b required 0/1/0", bad, DrainErr, DrainBusy);
      end
      clk_step();
   endtask
`endif

   task automatic test_random();
      logic          req_pending = 1'b0;
      logic          outstanding = 1'b0;
      logic          err_due     = 1'b0;
      logic          exp_rable;
      logic [EW-1:0] cur = '0;
      int            tcnt = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) begin
            fifo_q.push_back(rand_entry());
            fifo_show();
         end
         DrainEn   = ($urandom_range(0, 7) != 0);
         ReqReady  = ($urandom_range(0, 2) != 0);
         RespValid = outstanding ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
         RespErr   = ($urandom_range(0, 3) == 0);
         #1;
         exp_rable = DrainEn && fifo_q.size() != 0 &&
                     ((!req_pending && !outstanding) || (outstanding && RespValid));
         checks++;
         if (Rable !== exp_rable) begin
            errors++;
            $display("FAIL rnd_rable cycle %0d: got %b required %b", c, Rable, exp_rable);
         end
         checks++;
         if (ReqValid !== req_pending) begin
            errors++;
            $display("FAIL rnd_valid cycle %0d: got %b required %b", c, ReqValid, req_pending);
         end
         checks++;
         if (DrainBusy !== (req_pending || outstanding)) begin
            errors++;
            $display("FAIL rnd_busy cycle %0d: got %b required %b", c, DrainBusy, req_pending || outstanding);
         end
         checks++;
         if (DrainErr !== err_due) begin
            errors++;
            $display("FAIL rnd_err cycle %0d: got %b required %b", c, DrainErr, err_due);
         end
         if (req_pending) begin
            checks++;
            if ({ReqAddr, ReqData, ReqStrb} !== cur) begin
               errors++;
               $display("FAIL rnd_fields cycle %0d: got %h required %h", c, {ReqAddr, ReqData, ReqStrb}, cur);
            end
         end
         err_due = 1'b0;
         if (outstanding && RespValid) begin
            outstanding = 1'b0;
            err_due     = RespErr;
         end
`ifdef STORE_DRAIN_TIMEOUT_EN
         else if (outstanding) begin
            if (tcnt == int'(TOUT)) begin
               outstanding = 1'b0;
               err_due     = 1'b1;
            end else begin
               tcnt++;
            end
         end
`endif
         if (req_pending && ReqReady) begin
            req_pending = 1'b0;
            outstanding = 1'b1;
            tcnt        = 0;
         end
         if (exp_rable) begin
            req_pending = 1'b1;
            cur         = fifo_q[0];
         end
         clk_step();
      end
      drain_idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_error();
      test_drain_en();
`ifdef STORE_DRAIN_TIMEOUT_EN
      test_timeout();
`endif
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_store_drain.md
# lsu_store_drain

Drains committed stores from the LSU store FIFO into the data-cache write port. The FSM pops one entry at a time from the FIFO head and presents it as a valid/ready write request. It waits for the write response before it pops the next entry. It sits directly downstream of the LSU FIFO and consumes its head-peek output, empty flag and read strobe.

## Interface
- `ADDRW`, 32: store address width.
- `DATAW`, 32: store data width; byte strobe width is `DATAW/8`.
- `TOUT_LIMIT`, 255: response timeout in cycles, 8-bit value. Used only with `STORE_DRAIN_TIMEOUT_EN`.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `Clk` input, 1 bit: clock.
  - `Rest` input, 1 bit: asynchronous active-low reset.
- FIFO side:
  - `FifoPreOut` input, `ADDRW+DATAW+DATAW/8` bits: FIFO head entry, packed as {addr, data, strb}, MSB first.
  - `FifoEmpty` input, 1 bit: FIFO empty.
  - `Rable` output, 1 bit: one-cycle pop strobe to the FIFO.
- Control:
  - `DrainEn` input, 1 bit: drain permitted. When low, no new entry is popped; an in-flight transaction still completes.
- Write request:
  - `ReqValid` output, 1 bit: write request valid.
  - `ReqReady` input, 1 bit: cache accepts the request.
  - `ReqAddr` output, `ADDRW` bits: request address.
  - `ReqData` output, `DATAW` bits: request data.
  - `ReqStrb` output, `DATAW/8` bits: request byte strobes.
- Write response:
  - `RespValid` input, 1 bit: write response.
  - `RespErr` input, 1 bit: response error, qualified by `RespValid`.
- Status:
  - `DrainBusy` output, 1 bit: FSM is not in IDLE.
  - `DrainErr` output, 1 bit: one-cycle error pulse.

## Operation
- FSM states:
  - **IDLE**: no transaction in flight.
  - **REQ**: request presented, waiting for acceptance.
  - **WAIT**: request accepted, waiting for the response.
- Pop condition `take = DrainEn && !FifoEmpty`.
  - Evaluated in IDLE.
  - Also evaluated in WAIT in a cycle where `RespValid` is high.
- `Rable` is combinational: `take` in those states, 0 otherwise. It is high for at most one cycle per entry.
- On `take`: the clock edge registers `FifoPreOut` into `ReqAddr`/`ReqData`/`ReqStrb`, and the FSM enters REQ.
- IDLE transitions:
  - `take` -> REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `ReqValid`=1; address, data and strobes stay stable.
  - `ReqValid` never drops before `ReqReady`.
  - `ReqValid && ReqReady` -> WAIT.
- WAIT:
  - `RespValid` and `take` -> REQ with the new entry (back-to-back).
  - `RespValid` and not `take` -> IDLE.
  - `RespValid && RespErr` pulses `DrainErr` in the following cycle. The entry is dropped, not retried.
- `RespValid` outside WAIT is ignored.
- `DrainEn` falling while in REQ or WAIT does not abort the transaction.
- Pop spacing: `FifoPreOut` and `FifoEmpty` update one cycle after `Rable`. The FSM guarantees at least 2 cycles between pops, so it never samples a stale head.

## Timing
- Reset values (asynchronous): state IDLE; `Rable`, `ReqValid`, `DrainBusy`, `DrainErr` = 0; `ReqAddr`, `ReqData`, `ReqStrb` = 0.
- Latency:
  - Cycle 0: IDLE with `take` -> `Rable`=1.
  - Cycle 1: `ReqValid`=1.
  - With `ReqReady`=1 in cycle 1: WAIT in cycle 2.
  - Earliest `RespValid` is cycle 2.
- Minimum throughput is 2 cycles per store (REQ, WAIT) when `ReqReady` and `RespValid` are immediate.
- Reset mid-transaction: the FSM returns to IDLE immediately and the in-flight entry is lost. The FIFO is reset by the same reset.
- `DrainBusy` is registered and follows the state: high in REQ and WAIT.

## Configuration
- Macro `STORE_DRAIN_TIMEOUT_EN`.
- When defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without `RespValid`.
  - When the counter equals `TOUT_LIMIT`, the FSM pulses `DrainErr` and goes to IDLE. That cycle has no back-to-back pop.
  - A `RespValid` arriving in the same cycle as the limit takes priority as a normal response.
- When undefined: there is no counter, and WAIT holds indefinitely until `RespValid`.

## Test plan
- FIFO holds 1 entry {0x0000_1000, 0xDEAD_BEEF, 0xF}, `DrainEn`=1, `ReqReady`=1, `RespValid` in cycle 2:
  - `Rable` pulses in cycle 0.
  - `ReqValid` is high in cycle 1 with addr 0x1000, data 0xDEADBEEF, strb 0xF.
  - `DrainBusy` is 0 in cycle 3.
- Back-to-back: FIFO holds 3 entries, immediate ready and response:
  - 3 requests in order, 2 cycles apart.
  - Exactly 3 `Rable` pulses.
- Backpressure: hold `ReqReady`=0 for 5 cycles:
  - `ReqValid` stays high and the request fields stay unchanged.
  - No second `Rable`.
  - WAIT is entered the cycle after `ReqReady` rises.
- Error response: `RespValid`=`RespErr`=1:
  - `DrainErr` is high for exactly 1 cycle.
  - The next entry is still drained.
- `DrainEn`=0 with a non-empty FIFO: no `Rable` and no `ReqValid` for 20 cycles. Drop `DrainEn` mid-WAIT: the response completes, then the FSM returns to IDLE.
- Async reset asserted in REQ: outputs go to 0 without a clock edge. With `STORE_DRAIN_TIMEOUT_EN` and `TOUT_LIMIT`=4 and no response: `DrainErr` pulses after 4 WAIT cycles, then IDLE.
